// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the fetch port, the Memory-stage data port and the unified RAM
// handshake served by dmem_port_arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    logic              d_read;
    logic              d_write;
    logic [2:0]        d_mode;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;
    logic              ram_req;
    logic              ram_we;
    logic [2:0]        ram_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    // Pipeline stages and RAM model side
    modport master (
        output if_req, if_addr, d_read, d_write, d_mode, d_addr, d_wdata,
               ram_rdata, ram_ack,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               ram_req, ram_we, ram_mode, ram_addr, ram_wdata
    );

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_read, d_write, d_mode, d_addr, d_wdata,
               ram_rdata, ram_ack,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               ram_req, ram_we, ram_mode, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch and
// the data port. Define DMEM_ARB_RR_EN for round-robin, else data has priority.
module dmem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]        state;
    logic              ram_req_q;
    logic              ram_we_q;
    logic [2:0]        ram_mode_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_done_q;
    logic              d_done_q;

    logic if_pend;
    logic d_pend;
    logic grant_d;
    logic grant_i;

    // A request still held during its own done cycle is the finished one, not a new one.
    assign if_pend = bus.if_req & ~if_done_q;
    assign d_pend  = (bus.d_read | bus.d_write) & ~d_done_q;

`ifdef DMEM_ARB_RR_EN
    logic rr_d_first;

    assign grant_d = d_pend & (~if_pend | rr_d_first);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_d_first <= 1'b1;
        end else if (state == IDLE) begin
            if (grant_d)      rr_d_first <= 1'b0;
            else if (grant_i) rr_d_first <= 1'b1;
        end
    end
`else
    assign grant_d = d_pend;
`endif

    assign grant_i = if_pend & ~grant_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_mode_q  <= 3'b000;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        ram_we_q    <= bus.d_write;
                        ram_mode_q  <= bus.d_mode;
                        ram_addr_q  <= bus.d_addr;
                        ram_wdata_q <= bus.d_wdata;
                        ram_req_q   <= 1'b1;
                        state       <= BUSY_D;
                    end else if (grant_i) begin
                        ram_we_q   <= 1'b0;
                        ram_mode_q <= 3'b000;
                        ram_addr_q <= bus.if_addr;
                        ram_req_q  <= 1'b1;
                        state      <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (ram_req_q && bus.ram_ack) begin
                        if_rdata_q <= bus.ram_rdata;
                        if_done_q  <= 1'b1;
                        ram_req_q  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (ram_req_q && bus.ram_ack) begin
                        if (!ram_we_q) d_rdata_q <= bus.ram_rdata;
                        d_done_q  <= 1'b1;
                        ram_req_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ram_req_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_mode  = ram_mode_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = (bus.d_read | bus.d_write) & ~d_done_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: per-cycle vector table plus hand-written
// conflict, back-to-back, reset and flush sequences.
module tb_dmem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ifr, ifa, dr, dw, dm, da, dwd, ack, rd;
        logic [31:0] e_req, e_we, e_mode, e_addr, e_wdata;
        logic [31:0] e_ifd, e_dd, e_ifs, e_ds, e_ifrd, e_drd;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_mode    = 3'b000;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive_idle();

        // c0-c3 single fetch, c4-c9 store with 3 waits, c10-c11 stray ack, c12-c16 load
        vecs[0]  = '{1,32'h100,0,0,0,0,0,0,0,                       0,0,0,0,0,                         0,0,1,0,0,0};
        vecs[1]  = '{1,32'h100,0,0,0,0,0,1,32'hDEADBEEF,            1,0,0,32'h100,0,                   0,0,1,0,0,0};
        vecs[2]  = '{1,32'h100,0,0,0,0,0,0,0,                       0,0,0,32'h100,0,                   1,0,0,0,32'hDEADBEEF,0};
        vecs[3]  = '{0,0,0,0,0,0,0,0,0,                             0,0,0,32'h100,0,                   0,0,0,0,32'hDEADBEEF,0};
        vecs[4]  = '{0,0,0,1,2,32'h2000,32'h12345678,0,0,           0,0,0,32'h100,0,                   0,0,0,1,32'hDEADBEEF,0};
        vecs[5]  = '{0,0,0,1,2,32'h2000,32'h12345678,0,0,           1,1,2,32'h2000,32'h12345678,       0,0,0,1,32'hDEADBEEF,0};
        vecs[6]  = '{0,0,0,1,2,32'h2000,32'h12345678,0,0,           1,1,2,32'h2000,32'h12345678,       0,0,0,1,32'hDEADBEEF,0};
        vecs[7]  = '{0,0,0,1,2,32'h2000,32'h12345678,0,0,           1,1,2,32'h2000,32'h12345678,       0,0,0,1,32'hDEADBEEF,0};
        vecs[8]  = '{0,0,0,1,2,32'h2000,32'h12345678,1,32'hCAFEF00D,1,1,2,32'h2000,32'h12345678,       0,0,0,1,32'hDEADBEEF,0};
        vecs[9]  = '{0,0,0,1,2,32'h2000,32'h12345678,0,0,           0,1,2,32'h2000,32'h12345678,       0,1,0,0,32'hDEADBEEF,0};
        vecs[10] = '{0,0,0,0,0,0,0,1,32'h55,                        0,1,2,32'h2000,32'h12345678,       0,0,0,0,32'hDEADBEEF,0};
        vecs[11] = '{0,0,0,0,0,0,0,0,0,                             0,1,2,32'h2000,32'h12345678,       0,0,0,0,32'hDEADBEEF,0};
        vecs[12] = '{0,0,1,0,4,32'h3000,0,0,0,                      0,1,2,32'h2000,32'h12345678,       0,0,0,1,32'hDEADBEEF,0};
        vecs[13] = '{0,0,1,0,4,32'h3000,0,0,0,                      1,0,4,32'h3000,0,                  0,0,0,1,32'hDEADBEEF,0};
        vecs[14] = '{0,0,1,0,4,32'h3000,0,1,32'h0BADF00D,           1,0,4,32'h3000,0,                  0,0,0,1,32'hDEADBEEF,0};
        vecs[15] = '{0,0,1,0,4,32'h3000,0,0,0,                      0,0,4,32'h3000,0,                  0,1,0,0,32'hDEADBEEF,32'h0BADF00D};
        vecs[16] = '{0,0,0,0,0,0,0,0,0,                             0,0,4,32'h3000,0,                  0,0,0,0,32'hDEADBEEF,32'h0BADF00D};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst ram_req",   32'(bus.ram_req), 0);
        chk("rst ram_we",    32'(bus.ram_we), 0);
        chk("rst ram_addr",  bus.ram_addr, 0);
        chk("rst ram_wdata", bus.ram_wdata, 0);
        chk("rst ram_mode",  32'(bus.ram_mode), 0);
        chk("rst if_done",   32'(bus.if_done), 0);
        chk("rst d_done",    32'(bus.d_done), 0);
        chk("rst if_rdata",  bus.if_rdata, 0);
        chk("rst d_rdata",   bus.d_rdata, 0);
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus.if_req    = vecs[i].ifr[0];
            bus.if_addr   = vecs[i].ifa;
            bus.d_read    = vecs[i].dr[0];
            bus.d_write   = vecs[i].dw[0];
            bus.d_mode    = vecs[i].dm[2:0];
            bus.d_addr    = vecs[i].da;
            bus.d_wdata   = vecs[i].dwd;
            bus.ram_ack   = vecs[i].ack[0];
            bus.ram_rdata = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d ram_req", i),   32'(bus.ram_req),  vecs[i].e_req);
            chk($sformatf("v%0d ram_we", i),    32'(bus.ram_we),   vecs[i].e_we);
            chk($sformatf("v%0d ram_mode", i),  32'(bus.ram_mode), vecs[i].e_mode);
            chk($sformatf("v%0d ram_addr", i),  bus.ram_addr,      vecs[i].e_addr);
            chk($sformatf("v%0d ram_wdata", i), bus.ram_wdata,     vecs[i].e_wdata);
            chk($sformatf("v%0d if_done", i),   32'(bus.if_done),  vecs[i].e_ifd);
            chk($sformatf("v%0d d_done", i),    32'(bus.d_done),   vecs[i].e_dd);
            chk($sformatf("v%0d if_stall", i),  32'(bus.if_stall), vecs[i].e_ifs);
            chk($sformatf("v%0d d_stall", i),   32'(bus.d_stall),  vecs[i].e_ds);
            chk($sformatf("v%0d if_rdata", i),  bus.if_rdata,      vecs[i].e_ifrd);
            chk($sformatf("v%0d d_rdata", i),   bus.d_rdata,       vecs[i].e_drd);
            next_cycle();
        end
        drive_idle();
        next_cycle();

        // Conflict: first grant to data, repeat conflict depends on arbitration mode
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.d_read = 1'b1; bus.d_addr  = 32'h600;
        next_cycle();
        @(negedge clk);
        chk("cf1 ram_req",  32'(bus.ram_req), 1);
        chk("cf1 ram_addr", bus.ram_addr, 32'h600);
        chk("cf1 ram_we",   32'(bus.ram_we), 0);
        next_cycle();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h11111111;
        @(negedge clk);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("cf1 d_done",  32'(bus.d_done), 1);
        chk("cf1 if_done", 32'(bus.if_done), 0);
        chk("cf1 d_rdata", bus.d_rdata, 32'h11111111);
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.d_read = 1'b1; bus.d_addr  = 32'h600;
        @(negedge clk);
        chk("cf2 idle ram_req", 32'(bus.ram_req), 0);
        next_cycle();
        @(negedge clk);
        chk("cf2 ram_req", 32'(bus.ram_req), 1);
`ifdef DMEM_ARB_RR_EN
        chk("cf2 ram_addr", bus.ram_addr, 32'h500);
`else
        chk("cf2 ram_addr", bus.ram_addr, 32'h600);
`endif
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h22222222;
        next_cycle();
        drive_idle();
        @(negedge clk);
`ifdef DMEM_ARB_RR_EN
        chk("cf2 if_done",  32'(bus.if_done), 1);
        chk("cf2 if_rdata", bus.if_rdata, 32'h22222222);
`else
        chk("cf2 d_done",  32'(bus.d_done), 1);
        chk("cf2 d_rdata", bus.d_rdata, 32'h22222222);
`endif
        next_cycle();
        next_cycle();

        // Back-to-back loads with zero-wait memory answering whenever ram_req is high
        for (int c = 0; c < 11; c++) begin
            bus.d_read    = (c < 9);
            bus.d_addr    = 32'h400 + 32'(4 * (c / 3));
            bus.ram_ack   = bus.ram_req;
            bus.ram_rdata = bus.ram_addr ^ 32'hA5A50000;
            @(negedge clk);
            chk($sformatf("b2b c%0d ram_req", c), 32'(bus.ram_req), 32'((c % 3 == 1) && c < 9));
            chk($sformatf("b2b c%0d d_done", c),  32'(bus.d_done),  32'((c % 3 == 2) && c < 9));
            if (c == 2 || c == 5 || c == 8)
                chk($sformatf("b2b c%0d d_rdata", c), bus.d_rdata,
                    (32'h400 + 32'(4 * ((c - 2) / 3))) ^ 32'hA5A50000);
            next_cycle();
        end
        drive_idle();
        next_cycle();

        // Reset while waiting on the memory in BUSY_D
        bus.d_read = 1'b1; bus.d_addr = 32'h700;
        next_cycle();
        @(negedge clk);
        chk("rma busy ram_req", 32'(bus.ram_req), 1);
        rst_n = 1'b0;
        bus.d_read = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rma ram_req",  32'(bus.ram_req), 0);
        chk("rma d_done",   32'(bus.d_done), 0);
        chk("rma ram_addr", bus.ram_addr, 0);
        chk("rma d_rdata",  bus.d_rdata, 0);
        chk("rma if_rdata", bus.if_rdata, 0);
        next_cycle();
        @(negedge clk);
        chk("rma post d_done",  32'(bus.d_done), 0);
        chk("rma post ram_req", 32'(bus.ram_req), 0);
        next_cycle();

        // Flush: fetch dropped mid-transaction still completes exactly once
        bus.if_req = 1'b1; bus.if_addr = 32'h800;
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("fl ram_req",  32'(bus.ram_req), 1);
        chk("fl ram_addr", bus.ram_addr, 32'h800);
        chk("fl if_stall", 32'(bus.if_stall), 0);
        next_cycle();
        bus.ram_ack = 1'b1; bus.ram_rdata = 32'h33333333;
        next_cycle();
        bus.ram_ack = 1'b0;
        @(negedge clk);
        chk("fl if_done",  32'(bus.if_done), 1);
        chk("fl if_rdata", bus.if_rdata, 32'h33333333);
        chk("fl ram_req",  32'(bus.ram_req), 0);
        next_cycle();
        @(negedge clk);
        chk("fl done width", 32'(bus.if_done), 0);
        next_cycle();
        @(negedge clk);
        chk("fl idle ram_req", 32'(bus.ram_req), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares one single-port, variable-latency memory between the instruction-fetch port and the Memory-stage data port. It accepts one request at a time, drives the memory with a registered request/acknowledge handshake, and returns read data with a one-cycle done pulse to the winning requester. It produces per-port stall signals so the pipeline freezes until its access completes. It sits between the pipeline stages and the unified RAM model.

## Interface
Parameters:
- `ADDR_W`, default 32, memory address width.
- `DATA_W`, default 32, data word width.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `if_req`  in  1  instruction-fetch read request; held high until `if_done`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_done`=1 and held until the next fetch completes.
- `if_done`  out  1  one-cycle completion pulse for the fetch port.
- `if_stall`  out  1  `if_req & ~if_done` (combinational).
- `d_read`  in  1  data load request (`dmem_read` from Memory).
- `d_write`  in  1  data store request (`dmem_write` from Memory).
- `d_mode`  in  3  access size/sign mode (`dmem_mode`), forwarded unchanged.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load result; valid while `d_done`=1 and held until the next data access completes.
- `d_done`  out  1  one-cycle completion pulse for the data port.
- `d_stall`  out  1  `(d_read | d_write) & ~d_done` (combinational).
- `ram_req`  out  1  memory request; registered.
- `ram_we`  out  1  1 = write, 0 = read.
- `ram_mode`  out  3  latched `d_mode`; 3'b000 for fetches.
- `ram_addr`  out  ADDR_W  latched address.
- `ram_wdata`  out  DATA_W  latched store data.
- `ram_rdata`  in  DATA_W  memory read data; sampled on the `ram_ack` cycle.
- `ram_ack`  in  1  memory completion; valid only while `ram_req`=1.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if any request is pending, pick a winner (see Configuration), latch its address, `ram_we`, mode and write data, then go to BUSY_I or BUSY_D. `ram_req` goes high on the next cycle.
- BUSY_x: hold `ram_req`=1 and all latched `ram_*` outputs stable. On `ram_ack`=1, capture `ram_rdata` (reads only), drop `ram_req`, pulse `x_done` on the next cycle, and return to IDLE.
- On a write, `d_rdata` keeps its previous value; `d_done` still pulses.
- A requester that drops its request mid-transaction (flush) does not abort the access. The access completes and `done` pulses; the requester ignores it.
- Both `d_read` and `d_write` high is treated as a write.
- IDLE re-arbitrates in the same cycle `done` is asserted, so back-to-back accesses are possible.
- `d_read`/`d_write` held during the `d_done` cycle is not counted as a new request. A new data request is recognised only from the cycle after `d_done`. The same rule applies to `if_req`.

## Timing
- Reset (`rst_n`=0 at an edge): state = IDLE; `ram_req`, `ram_we`, `if_done`, `d_done` = 0; `ram_addr`, `ram_wdata`, `ram_mode`, `if_rdata`, `d_rdata` = 0; round-robin pointer = data.
- Reset mid-transaction abandons the access immediately. `ram_req` is 0 the cycle after reset, and no done pulse is produced.
- Latency: request seen in IDLE at cycle 0 → `ram_req`=1 at cycle 1 → earliest `ram_ack` at cycle 1 → `done` and data valid at cycle 2. Each memory wait cycle adds one cycle.
- `ram_ack` while `ram_req`=0 is ignored.
- `done` is exactly one cycle wide.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. When both ports request in IDLE, the port not granted last wins; the pointer updates on every grant.
- Not defined: fixed priority. The data port always wins on conflict, because it carries the older instruction. Fetch can starve while data requests continue.

## Test plan
- Single fetch, zero-wait memory: `if_req`=1, `if_addr`=0x100, `ram_ack` on first `ram_req` cycle with `ram_rdata`=0xDEADBEEF → `if_done`=1 at cycle 2 with `if_rdata`=0xDEADBEEF; `if_stall`=1 on cycles 0–1.
- Store with 3 wait states: `d_write`=1, `d_addr`=0x2000, `d_wdata`=0x12345678, `d_mode`=3'b010 → `ram_we`=1 and all `ram_*` stable for 4 cycles; `d_done` at cycle 5; `d_rdata` unchanged.
- Conflict: `if_req` and `d_read` both asserted in IDLE → first grant goes to data. With `DMEM_ARB_RR_EN`, a repeat conflict after that grant goes to fetch; without it, data wins again.
- Back-to-back: three consecutive loads with zero-wait memory → `d_done` pulses every 3 cycles with no lost or duplicated access.
- Reset mid-access: `rst_n`=0 while in BUSY_D with `ram_ack` low → next cycle `ram_req`=0, no `d_done`, all outputs at reset values.
- Flush: `if_req` dropped while in BUSY_I → transaction completes, `if_done` pulses once, and the arbiter returns to IDLE.
